// File: rtl/memport_pkg.sv
// Shared types and constants for the memory-port arbiter.
package memport_pkg;

  // Which master a read response belongs to.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // One entry of the read-latency pipeline.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // Legal RAM read latencies.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Keeps the tag pipeline depth inside the legal latency range.
  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/memport_tagpipe.sv
// Shift register of read tags that follows each access through the RAM latency.
module memport_tagpipe
  import memport_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [DEPTH];

  // Shift one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '{valid: 1'b0, owner: OWN_FETCH};
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/memport_arb.sv
// Single-port RAM arbiter shared by the fetch and data masters.
//
// Handshake: a master raises its req with address/data and holds them stable
// until the cycle its gnt is high; that cycle is the transfer. Read results
// come back as a one-cycle valid pulse with data, in issue order, and there is
// no backpressure on valid -- masters must take it the cycle it pulses.
module memport_arb
  import memport_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int RD_LAT    = 1,
  parameter bit PRIO_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch master
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic              ignt_o,
  output logic              ivalid_o,
  output logic [DATA_W-1:0] idata_o,
  // data master
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] ddin_i,
  output logic              dgnt_o,
  output logic              dvalid_o,
  output logic [DATA_W-1:0] ddata_o,
  // RAM side
  output logic [ADDR_W-1:0] maddr_o,
  output logic [DATA_W-1:0] mdin_o,
  output logic              mwe_o,
  input  logic [DATA_W-1:0] mdout_i,
  // arbiter state: 1 = data port won the last conflict
  output logic              last_gnt_o
);

  // The tag pipe covers the RAM latency; the valid/data output registers
  // below are the final stage, giving RD_LAT+1 cycles from grant to valid.
  localparam int PIPE_DEPTH = clamp_rd_lat(RD_LAT);

  owner_e            last_gnt_q, last_gnt_d;
  logic              ignt, dgnt;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mdin_q, mdin_d;
  logic              mwe;
  tag_t              tag_in, tag_out;
  logic              resp_fetch, resp_data;
  logic              ivalid_q, dvalid_q;
  logic [DATA_W-1:0] idata_q, ddata_q;

  // Arbitration: single requester wins; conflicts go to data or alternate.
  always_comb begin
    ignt       = 1'b0;
    dgnt       = 1'b0;
    last_gnt_d = last_gnt_q;
    if (!rst_i) begin
      if (ireq_i && dreq_i) begin
        if (PRIO_DATA) begin
          dgnt = 1'b1;
        end else if (last_gnt_q == OWN_DATA) begin
          ignt       = 1'b1;
          last_gnt_d = OWN_FETCH;
        end else begin
          dgnt       = 1'b1;
          last_gnt_d = OWN_DATA;
        end
      end else begin
        ignt = ireq_i;
        dgnt = dreq_i;
      end
    end
  end

  // RAM mux: the granted port drives the RAM; otherwise address/data hold.
  always_comb begin
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    mwe     = 1'b0;
    if (dgnt) begin
      maddr_d = daddr_i;
      mdin_d  = ddin_i;
      mwe     = dwe_i;
    end else if (ignt) begin
      maddr_d = iaddr_i;
    end
  end

  // Tag for this cycle's access: only reads expect a response.
  always_comb begin
    tag_in.valid = ignt || (dgnt && !dwe_i);
    tag_in.owner = dgnt ? OWN_DATA : OWN_FETCH;
  end

  // Arbiter state and held RAM address/data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_q <= OWN_DATA;
      maddr_q    <= '0;
      mdin_q     <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      maddr_q    <= maddr_d;
      mdin_q     <= mdin_d;
    end
  end

  memport_tagpipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_tagpipe (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  assign resp_fetch = tag_out.valid && (tag_out.owner == OWN_FETCH);
  assign resp_data  = tag_out.valid && (tag_out.owner == OWN_DATA);

  // Capture RAM read data for the owning port and pulse its valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      idata_q  <= '0;
      ddata_q  <= '0;
    end else begin
      ivalid_q <= resp_fetch;
      dvalid_q <= resp_data;
      if (resp_fetch) idata_q <= mdout_i;
      if (resp_data)  ddata_q <= mdout_i;
    end
  end

  assign ignt_o     = ignt;
  assign dgnt_o     = dgnt;
  assign maddr_o    = maddr_d;
  assign mdin_o     = mdin_d;
  assign mwe_o      = mwe;
  assign ivalid_o   = ivalid_q;
  assign dvalid_o   = dvalid_q;
  assign idata_o    = idata_q;
  assign ddata_o    = ddata_q;
  assign last_gnt_o = (last_gnt_q == OWN_DATA);

endmodule

// File: tb/tb_memport_arb.sv
// Bench for memport_arb: three instances (RD_LAT 1/2/3, priority/round-robin)
// each with its own RAM model, checked every cycle against a reference model.
module tb_memport_arb;

  localparam int NI = 3;
  localparam int DW = 16;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          ireq   [NI];
  logic [AW-1:0] iaddr  [NI];
  logic          ignt   [NI];
  logic          ivalid [NI];
  logic [DW-1:0] idata  [NI];
  logic          dreq   [NI];
  logic          dwe    [NI];
  logic [AW-1:0] daddr  [NI];
  logic [DW-1:0] ddin   [NI];
  logic          dgnt   [NI];
  logic          dvalid [NI];
  logic [DW-1:0] ddata  [NI];
  logic [AW-1:0] maddr  [NI];
  logic [DW-1:0] mdin   [NI];
  logic          mwe    [NI];
  logic [DW-1:0] mdout  [NI];
  logic          lastg  [NI];

  memport_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .PRIO_DATA(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst),
    .ireq_i(ireq[0]), .iaddr_i(iaddr[0]), .ignt_o(ignt[0]), .ivalid_o(ivalid[0]), .idata_o(idata[0]),
    .dreq_i(dreq[0]), .dwe_i(dwe[0]), .daddr_i(daddr[0]), .ddin_i(ddin[0]),
    .dgnt_o(dgnt[0]), .dvalid_o(dvalid[0]), .ddata_o(ddata[0]),
    .maddr_o(maddr[0]), .mdin_o(mdin[0]), .mwe_o(mwe[0]), .mdout_i(mdout[0]), .last_gnt_o(lastg[0]));

  memport_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .PRIO_DATA(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst),
    .ireq_i(ireq[1]), .iaddr_i(iaddr[1]), .ignt_o(ignt[1]), .ivalid_o(ivalid[1]), .idata_o(idata[1]),
    .dreq_i(dreq[1]), .dwe_i(dwe[1]), .daddr_i(daddr[1]), .ddin_i(ddin[1]),
    .dgnt_o(dgnt[1]), .dvalid_o(dvalid[1]), .ddata_o(ddata[1]),
    .maddr_o(maddr[1]), .mdin_o(mdin[1]), .mwe_o(mwe[1]), .mdout_i(mdout[1]), .last_gnt_o(lastg[1]));

  memport_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .PRIO_DATA(1'b1)) u2 (
    .clk_i(clk), .rst_i(rst),
    .ireq_i(ireq[2]), .iaddr_i(iaddr[2]), .ignt_o(ignt[2]), .ivalid_o(ivalid[2]), .idata_o(idata[2]),
    .dreq_i(dreq[2]), .dwe_i(dwe[2]), .daddr_i(daddr[2]), .ddin_i(ddin[2]),
    .dgnt_o(dgnt[2]), .dvalid_o(dvalid[2]), .ddata_o(ddata[2]),
    .maddr_o(maddr[2]), .mdin_o(mdin[2]), .mwe_o(mwe[2]), .mdout_i(mdout[2]), .last_gnt_o(lastg[2]));

  // ---------------- RAM models ----------------
  function automatic logic [DW-1:0] pat(input int k, input int a);
    if (a == 5) return 16'h1234;
    return 16'(k * 4096 + a * 257 + 66);
  endfunction

  logic [DW-1:0] mem [NI][64];
  logic [DW-1:0] rp  [NI][3];
  logic          load_mem;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (load_mem) begin
        for (int a = 0; a < 64; a++) mem[k][a] <= pat(k, a);
      end else if (mwe[k]) begin
        mem[k][maddr[k]] <= mdin[k];
      end
      rp[k][0] <= mem[k][maddr[k]];
      rp[k][1] <= rp[k][0];
      rp[k][2] <= rp[k][1];
    end
  end

  assign mdout[0] = rp[0][0];
  assign mdout[1] = rp[1][1];
  assign mdout[2] = rp[2][2];

  // ---------------- reference model + scoreboard ----------------
  int            lat_of  [NI] = '{1, 2, 3};
  bit            prio_of [NI] = '{1'b1, 1'b0, 1'b1};
  logic [DW-1:0] sh      [NI][64];
  bit            last_data [NI];
  logic [AW-1:0] maddr_m [NI];
  logic [DW-1:0] mdin_m  [NI];
  bit            gi_m    [NI];
  bit            gd_m    [NI];
  // entry = {due cycle[31:0], owner is data, word[15:0]}
  logic [48:0]   exp_q   [NI][$];
  int            cyc, n_checks, n_errors;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_all();
    logic [48:0]   e;
    bit            ev_i, ev_d;
    logic [DW-1:0] ed;
    for (int k = 0; k < NI; k++) begin
      gi_m[k] = 1'b0;
      gd_m[k] = 1'b0;
      if (rst) begin
        exp_q[k].delete();
        last_data[k] = 1'b1;
        maddr_m[k]   = '0;
        mdin_m[k]    = '0;
        chk("rst_ignt",   k, 32'(ignt[k]),   0);
        chk("rst_dgnt",   k, 32'(dgnt[k]),   0);
        chk("rst_mwe",    k, 32'(mwe[k]),    0);
        chk("rst_ivalid", k, 32'(ivalid[k]), 0);
        chk("rst_dvalid", k, 32'(dvalid[k]), 0);
        chk("rst_idata",  k, 32'(idata[k]),  0);
        chk("rst_ddata",  k, 32'(ddata[k]),  0);
        chk("rst_maddr",  k, 32'(maddr[k]),  0);
        chk("rst_mdin",   k, 32'(mdin[k]),   0);
      end else begin
        chk("last_gnt", k, 32'(lastg[k]), 32'(last_data[k]));
        // who wins: single requester, else data (priority) or the port
        // that did not win the previous conflict (round-robin)
        if (ireq[k] && dreq[k]) begin
          if (prio_of[k]) begin
            gd_m[k] = 1'b1;
          end else begin
            gi_m[k]      = last_data[k];
            gd_m[k]      = !last_data[k];
            last_data[k] = gd_m[k];
          end
        end else begin
          gi_m[k] = ireq[k];
          gd_m[k] = dreq[k];
        end
        if (gd_m[k]) begin
          maddr_m[k] = daddr[k];
          mdin_m[k]  = ddin[k];
        end else if (gi_m[k]) begin
          maddr_m[k] = iaddr[k];
        end
        chk("ignt",  k, 32'(ignt[k]),  32'(gi_m[k]));
        chk("dgnt",  k, 32'(dgnt[k]),  32'(gd_m[k]));
        chk("mwe",   k, 32'(mwe[k]),   32'(gd_m[k] && dwe[k]));
        chk("maddr", k, 32'(maddr[k]), 32'(maddr_m[k]));
        chk("mdin",  k, 32'(mdin[k]),  32'(mdin_m[k]));
        ev_i = 1'b0;
        ev_d = 1'b0;
        ed   = '0;
        if (exp_q[k].size() > 0) begin
          e = exp_q[k][0];
          if (e[48:17] == 32'(cyc)) begin
            e  = exp_q[k].pop_front();
            ed = e[15:0];
            if (e[16]) ev_d = 1'b1;
            else       ev_i = 1'b1;
          end
        end
        chk("ivalid", k, 32'(ivalid[k]), 32'(ev_i));
        chk("dvalid", k, 32'(dvalid[k]), 32'(ev_d));
        if (ev_i) chk("idata", k, 32'(idata[k]), 32'(ed));
        if (ev_d) chk("ddata", k, 32'(ddata[k]), 32'(ed));
        if (gi_m[k]) exp_q[k].push_back({32'(cyc + lat_of[k] + 1), 1'b0, sh[k][iaddr[k]]});
        if (gd_m[k]) begin
          if (dwe[k]) sh[k][daddr[k]] = ddin[k];
          else        exp_q[k].push_back({32'(cyc + lat_of[k] + 1), 1'b1, sh[k][daddr[k]]});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      ireq[k] = 1'b0; iaddr[k] = '0;
      dreq[k] = 1'b0; dwe[k] = 1'b0; daddr[k] = '0; ddin[k] = '0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    model_all();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    idle_all();
    for (int i = 0; i < n; i++) begin
      settle();
      finish_cycle();
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    settle();
    finish_cycle();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic ireq, dreq, dwe;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] ddin;
    logic e_ig, e_dg, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
  } vec_t;

  vec_t tbl [7];

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0; n_checks = 0; n_errors = 0;
    rst = 1'b1;
    load_mem = 1'b1;
    idle_all();
    for (int k = 0; k < NI; k++) begin
      last_data[k] = 1'b1;
      maddr_m[k] = '0;
      mdin_m[k] = '0;
      gi_m[k] = 1'b0;
      gd_m[k] = 1'b0;
      for (int a = 0; a < 64; a++) sh[k][a] = pat(k, a);
    end
    for (int i = 0; i < 2; i++) begin
      settle();
      finish_cycle();
    end
    load_mem = 1'b0;
    rst = 1'b0;

    // table: arbitration and RAM mux on the data-priority instance
    tbl[0] = '{1'b1, 1'b0, 1'b0, 6'd5,  6'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 6'd5,  16'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 6'd0,  6'd9,  16'hA5A5, 1'b0, 1'b1, 1'b1, 6'd9,  16'hA5A5};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 6'd7,  6'd12, 16'h1111, 1'b0, 1'b1, 1'b0, 6'd12, 16'h1111};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 6'd7,  6'd12, 16'h2222, 1'b0, 1'b0, 1'b0, 6'd12, 16'h1111};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 6'd33, 6'd63, 16'h5A5A, 1'b0, 1'b1, 1'b1, 6'd63, 16'h5A5A};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 6'd63, 16'h5A5A};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 6'd0,  6'd0,  16'hFFFF, 1'b1, 1'b0, 1'b0, 6'd0,  16'h5A5A};
    for (int r = 0; r < 7; r++) begin
      ireq[0] = tbl[r].ireq;  iaddr[0] = tbl[r].iaddr;
      dreq[0] = tbl[r].dreq;  dwe[0] = tbl[r].dwe;
      daddr[0] = tbl[r].daddr; ddin[0] = tbl[r].ddin;
      settle();
      chk("tbl_ignt",  r, 32'(ignt[0]),  32'(tbl[r].e_ig));
      chk("tbl_dgnt",  r, 32'(dgnt[0]),  32'(tbl[r].e_dg));
      chk("tbl_mwe",   r, 32'(mwe[0]),   32'(tbl[r].e_we));
      chk("tbl_maddr", r, 32'(maddr[0]), 32'(tbl[r].e_addr));
      chk("tbl_mdin",  r, 32'(mdin[0]),  32'(tbl[r].e_din));
      finish_cycle();
    end
    idle_cycles(5);
    do_reset();

    // fetch read of word 5, RD_LAT=1: valid two cycles after grant
    ireq[0] = 1'b1; iaddr[0] = 6'd5;
    settle(); chk("p1_ignt", 0, 32'(ignt[0]), 1); finish_cycle();
    ireq[0] = 1'b0;
    settle(); chk("p1_ivalid_early", 0, 32'(ivalid[0]), 0); finish_cycle();
    settle();
    chk("p1_ivalid", 0, 32'(ivalid[0]), 1);
    chk("p1_idata",  0, 32'(idata[0]),  32'h1234);
    chk("p1_dvalid", 0, 32'(dvalid[0]), 0);
    finish_cycle();

    // write then read-back on consecutive cycles
    dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 6'd3; ddin[0] = 16'hBEEF;
    settle(); chk("p2_dgnt_w", 0, 32'(dgnt[0]), 1); chk("p2_mwe_w", 0, 32'(mwe[0]), 1); finish_cycle();
    dwe[0] = 1'b0; ddin[0] = 16'h0000;
    settle(); chk("p2_dgnt_r", 0, 32'(dgnt[0]), 1); chk("p2_mwe_r", 0, 32'(mwe[0]), 0); finish_cycle();
    dreq[0] = 1'b0;
    settle(); chk("p2_mwe_idle", 0, 32'(mwe[0]), 0); chk("p2_dvalid_early", 0, 32'(dvalid[0]), 0); finish_cycle();
    settle(); chk("p2_dvalid", 0, 32'(dvalid[0]), 1); chk("p2_ddata", 0, 32'(ddata[0]), 32'hBEEF); finish_cycle();
    idle_cycles(3);

    // round-robin: continuous conflict alternates starting with fetch
    for (int j = 0; j < 6; j++) begin
      ireq[1] = 1'b1; iaddr[1] = 6'(j);
      dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 6'(j + 8);
      settle();
      chk("rr_ignt", j, 32'(ignt[1]), 32'((j % 2) == 0));
      chk("rr_dgnt", j, 32'(dgnt[1]), 32'((j % 2) == 1));
      finish_cycle();
    end
    idle_cycles(5);

    // priority: data wins every conflict, fetch only once data drops
    for (int j = 0; j < 4; j++) begin
      ireq[0] = 1'b1; iaddr[0] = 6'd20;
      dreq[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 6'(j + 30);
      settle();
      chk("pr_dgnt", j, 32'(dgnt[0]), 1);
      chk("pr_ignt", j, 32'(ignt[0]), 0);
      finish_cycle();
    end
    dreq[0] = 1'b0;
    settle(); chk("pr_ignt_after", 0, 32'(ignt[0]), 1); finish_cycle();
    idle_cycles(4);

    // reset one cycle after a read grant with RD_LAT=3: response dropped
    ireq[2] = 1'b1; iaddr[2] = 6'd5;
    settle(); chk("rs_ignt", 2, 32'(ignt[2]), 1); finish_cycle();
    rst = 1'b1; dreq[2] = 1'b1;
    settle(); chk("rs_ignt_in_rst", 2, 32'(ignt[2]), 0); chk("rs_dgnt_in_rst", 2, 32'(dgnt[2]), 0); finish_cycle();
    rst = 1'b0;
    idle_all();
    for (int j = 0; j < 6; j++) begin
      settle();
      chk("rs_no_ivalid", j, 32'(ivalid[2]), 0);
      chk("rs_no_dvalid", j, 32'(dvalid[2]), 0);
      finish_cycle();
    end

    // interleaved stream, RD_LAT=2: I@1, D@2, I@3
    ireq[1] = 1'b1; iaddr[1] = 6'd1;
    settle(); finish_cycle();
    ireq[1] = 1'b0; dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 6'd2;
    settle(); finish_cycle();
    dreq[1] = 1'b0; ireq[1] = 1'b1; iaddr[1] = 6'd3;
    settle(); finish_cycle();
    ireq[1] = 1'b0;
    settle();
    chk("il_ivalid1", 1, 32'(ivalid[1]), 1); chk("il_dvalid1", 1, 32'(dvalid[1]), 0);
    chk("il_idata1", 1, 32'(idata[1]), 32'(pat(1, 1)));
    finish_cycle();
    settle();
    chk("il_dvalid2", 1, 32'(dvalid[1]), 1); chk("il_ivalid2", 1, 32'(ivalid[1]), 0);
    chk("il_ddata2", 1, 32'(ddata[1]), 32'(pat(1, 2)));
    finish_cycle();
    settle();
    chk("il_ivalid3", 1, 32'(ivalid[1]), 1);
    chk("il_idata3", 1, 32'(idata[1]), 32'(pat(1, 3)));
    finish_cycle();
    idle_cycles(3);

    // random traffic with held requests and one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      rst = (i == 200);
      for (int k = 0; k < NI; k++) begin
        if (!(ireq[k] && !gi_m[k])) begin
          ireq[k]  = ($urandom_range(0, 2) != 0);
          iaddr[k] = 6'($urandom_range(0, 63));
        end
        if (!(dreq[k] && !gd_m[k])) begin
          dreq[k]  = ($urandom_range(0, 2) != 0);
          dwe[k]   = ($urandom_range(0, 1) == 1);
          daddr[k] = 6'($urandom_range(0, 15));
          ddin[k]  = 16'($urandom);
        end
      end
      settle();
      finish_cycle();
    end
    rst = 1'b0;
    idle_cycles(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
